// File: rtl/fc.sv
// Fibre Channel receive word-sync shared definitions.
// K28.5 comma code and the sync FSM state type.
package fc;

  localparam logic [7:0] K28_5 = 8'hBC;

  typedef enum logic [1:0] {
    LOSS,
    ACQ,
    SYNC
  } sync_state_t;

  function automatic logic [1:0] low_ofs(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

endpackage

// File: rtl/fc_byte_realign.sv
// Picks BYTES line bytes from {cur, prev} at a byte offset and
// byte-swaps them into big-endian 32-bit words.
module fc_byte_realign #(
  parameter int BYTES = 4
) (
  input  logic [8*BYTES-1:0] cur_data,
  input  logic [BYTES-1:0]   cur_k,
  input  logic [8*BYTES-1:0] prev_data,
  input  logic [BYTES-1:0]   prev_k,
  input  logic [1:0]         lane,
  output logic [8*BYTES-1:0] word_data,
  output logic [BYTES-1:0]   word_k
);

  localparam int DW = $clog2(16*BYTES);
  localparam int KW = $clog2(2*BYTES);

  logic [16*BYTES-1:0] cat_d;
  logic [2*BYTES-1:0]  cat_k;
  logic [DW-1:0]       d_base;
  logic [KW-1:0]       k_base;
  logic [8*BYTES-1:0]  sel_d;
  logic [BYTES-1:0]    sel_k;

  // prev sits in the low bytes: it was first on the line
  assign cat_d  = {cur_data, prev_data};
  assign cat_k  = {cur_k, prev_k};
  assign d_base = DW'({lane, 3'b000});
  assign k_base = KW'(lane);
  assign sel_d  = cat_d[d_base +: 8*BYTES];
  assign sel_k  = cat_k[k_base +: BYTES];

  always_comb begin
    word_data = '0;
    word_k    = '0;
    for (int i = 0; i < BYTES; i++) begin
      word_data[8*(BYTES-1-i) +: 8] = sel_d[8*i +: 8];
      word_k[BYTES-1-i]             = sel_k[i];
    end
  end

endmodule

// File: rtl/fc_rx_word_sync.sv
// Receive word alignment: comma-based sync FSM, error statistics
// and a two-beat realignment pipeline.
module fc_rx_word_sync
  import fc::*;
#(
  parameter int BYTES      = 4,
  parameter int ACQ_COUNT  = 3,
  parameter int LOSS_COUNT = 4,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [8*BYTES-1:0] in_data,
  input  logic [BYTES-1:0]   in_datak,
  input  logic [BYTES-1:0]   in_err,
  input  logic               in_valid,
  input  logic               clear_cnt,
  output logic [8*BYTES-1:0] out_data,
  output logic [BYTES-1:0]   out_datak,
  output logic               out_valid,
  output logic               synced,
  output logic [1:0]         align_lane,
  output logic [CNT_W-1:0]   loss_cnt,
  output logic [CNT_W-1:0]   err_word_cnt
);

  if (BYTES != 4 && BYTES != 8) begin : g_bad_bytes
    $error("fc_rx_word_sync: BYTES must be 4 or 8");
  end

  localparam int AW = $clog2(ACQ_COUNT + 1);
  localparam int BW = $clog2(LOSS_COUNT + 1);

  sync_state_t        state;
  logic [AW-1:0]      acq_cnt;
  logic [BW-1:0]      bad_cnt;
  logic [8*BYTES-1:0] prev_data;
  logic [BYTES-1:0]   prev_k;
  logic [8*BYTES-1:0] word_data;
  logic [BYTES-1:0]   word_k;

  logic [3:0] ofs_hit;
  logic [3:0] lane_mask;
  logic       has_err;
  logic       has_comma;
  logic       wrong_comma;
  logic       bad_beat;
  logic       in_sync;
  logic       err_inc;
  logic       loss_inc;

  always_comb begin
    ofs_hit = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (in_datak[i] && in_data[8*i +: 8] == K28_5)
        ofs_hit[2'(i)] = 1'b1;
    end
  end

  assign lane_mask   = 4'b0001 << align_lane;
  assign has_err     = |in_err;
  assign has_comma   = |ofs_hit;
  assign wrong_comma = |(ofs_hit & ~lane_mask);
  assign bad_beat    = has_err | wrong_comma;
  assign in_sync     = (state == SYNC);
  assign err_inc     = in_valid && in_sync && bad_beat;
  assign loss_inc    = err_inc &&
                       (bad_cnt >= BW'(LOSS_COUNT - 1));

  fc_byte_realign #(
    .BYTES(BYTES)
  ) u_realign (
    .cur_data (in_data),
    .cur_k    (in_datak),
    .prev_data(prev_data),
    .prev_k   (prev_k),
    .lane     (align_lane),
    .word_data(word_data),
    .word_k   (word_k)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= LOSS;
      synced     <= 1'b0;
      align_lane <= 2'd0;
      acq_cnt    <= '0;
      bad_cnt    <= '0;
    end else if (in_valid) begin
      unique case (state)
        LOSS: begin
          if (has_comma && !has_err) begin
            state      <= ACQ;
            align_lane <= low_ofs(ofs_hit);
            acq_cnt    <= AW'(1);
          end
        end
        ACQ: begin
          if (has_err) begin
            state   <= LOSS;
            acq_cnt <= '0;
          end else if (wrong_comma) begin
            align_lane <= low_ofs(ofs_hit & ~lane_mask);
            acq_cnt    <= AW'(1);
          end else if (ofs_hit[align_lane]) begin
            if (acq_cnt >= AW'(ACQ_COUNT - 1)) begin
              state   <= SYNC;
              synced  <= 1'b1;
              acq_cnt <= '0;
              bad_cnt <= '0;
            end else begin
              acq_cnt <= acq_cnt + AW'(1);
            end
          end
        end
        SYNC: begin
          if (!bad_beat) begin
            bad_cnt <= '0;
          end else if (loss_inc) begin
            state   <= LOSS;
            synced  <= 1'b0;
            bad_cnt <= '0;
          end else begin
            bad_cnt <= bad_cnt + BW'(1);
          end
        end
        default: begin
          state  <= LOSS;
          synced <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_data <= '0;
      prev_k    <= '0;
      out_data  <= '0;
      out_datak <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid && in_sync;
      if (in_valid) begin
        prev_data <= in_data;
        prev_k    <= in_datak;
        out_data  <= word_data;
        out_datak <= word_k;
      end
    end
  end

  // counters saturate; clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loss_cnt     <= '0;
      err_word_cnt <= '0;
    end else if (clear_cnt) begin
      loss_cnt     <= '0;
      err_word_cnt <= '0;
    end else begin
      if (loss_inc && loss_cnt != '1)
        loss_cnt <= loss_cnt + CNT_W'(1);
      if (err_inc && err_word_cnt != '1)
        err_word_cnt <= err_word_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/fc_rx_word_sync.md
FC_RX_WORD_SYNC -- requirements
Module: fc_rx_word_sync

Interface
REQ-001 Parameter BYTES, default 4, bytes per beat; legal values 4 and 8 only.
REQ-002 Parameter ACQ_COUNT, default 3, comma beats at one offset needed to gain sync.
REQ-003 Parameter LOSS_COUNT, default 4, consecutive invalid beats that cause loss of sync.
REQ-004 Parameter CNT_W, default 16, width of the statistics counters.
REQ-005 clk  in  1  sole clock; all logic is on the rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 in_data  in  8*BYTES  raw little-endian PHY bytes; byte 0 (bits 7:0) is first on the line.
REQ-008 in_datak  in  BYTES  per-byte K flag.
REQ-009 in_err  in  BYTES  per-byte code or disparity error.
REQ-010 in_valid  in  1  beat qualifier.
REQ-011 clear_cnt  in  1  synchronous clear of both counters.
REQ-012 out_data  out  8*BYTES  aligned big-endian words; word j (j=0 first on the line) sits at bits [8*BYTES-1-32*j -: 32], with its first byte in the MSB.
REQ-013 out_datak  out  BYTES  K flags, mapped bit-for-bit the same way as the bytes of out_data.
REQ-014 out_valid  out  1  output beat valid.
REQ-015 synced  out  1  high while the FSM is in SYNC.
REQ-016 align_lane  out  2  locked byte offset, 0..3.
REQ-017 loss_cnt  out  CNT_W  number of SYNC->LOSS transitions.
REQ-018 err_word_cnt  out  CNT_W  number of invalid beats seen while in SYNC.

Function
REQ-019 Comma: byte i where in_data byte i = 8'hBC and in_datak[i] = 1; its offset is i mod 4.
REQ-020 A beat is invalid if in_valid = 1 and either any in_err bit is set or a comma appears at an offset other than align_lane.
REQ-021 While in_valid = 0: the FSM, counters and previous-beat register all hold, and out_valid is 0 on the next cycle.
REQ-022 Realignment source: {current beat, previous valid beat}. The output takes the BYTES consecutive line bytes starting at byte align_lane of the previous beat.
REQ-023 Latency is exactly 2 valid beats from input to out_data, with out_data and out_datak registered.
REQ-024 FSM states are LOSS, ACQ and SYNC; the reset state is LOSS.
REQ-025 LOSS: on a beat with a comma and no in_err, go to ACQ, set align_lane to the lowest comma offset, and set acq_cnt to 1.
REQ-026 ACQ, on an error-free beat with a comma at align_lane: increment acq_cnt; when it reaches ACQ_COUNT, go to SYNC and clear bad_cnt.
REQ-027 ACQ, on a comma at a different offset: relock align_lane to the new offset and set acq_cnt to 1.
REQ-028 ACQ, on an in_err beat: return to LOSS.
REQ-029 ACQ, on a beat without a comma: hold.
REQ-030 SYNC: an invalid beat increments bad_cnt; a valid beat clears it.
REQ-031 SYNC: when bad_cnt reaches LOSS_COUNT, go to LOSS and increment loss_cnt in the same cycle.
REQ-032 A change of align_lane takes effect for the realignment on the following valid beat.
REQ-033 out_valid is registered = (a valid beat is leaving the pipeline) AND (state = SYNC before this cycle's update).
REQ-034 Both counters saturate at 2^CNT_W-1 and do not wrap.
REQ-035 clear_cnt = 1 zeroes both counters and wins over a same-cycle increment.
REQ-036 synced is registered and equals (state = SYNC).

Reset
REQ-037 reset_n low immediately forces: state LOSS, align_lane 0, acq_cnt 0, bad_cnt 0, both counters 0, out_valid 0, synced 0, out_data 0, out_datak 0, previous-beat register 0.
REQ-038 Reset asserted mid-stream discards all in-flight beats; after release, sync must be reacquired from LOSS.

Structure
REQ-039 Package fc holds the constant K28_5 = 8'hBC and the enum sync_state_t {LOSS, ACQ, SYNC}.
REQ-040 The concatenate/shift/byte-swap datapath is a sub-module, fc_byte_realign, parametrised by BYTES.
REQ-041 The top level contains only the FSM, the counters and the pipeline control.

Verification
REQ-042 BYTES=4: three beats with 0xBC/K at byte 2, no errors -> synced = 1 after the 3rd beat, align_lane = 2, and the first out_valid beat has out_data[31:24] = 8'hBC.
REQ-043 In SYNC: 4 consecutive beats with in_err = 4'b0001 -> synced = 0, loss_cnt = 1, err_word_cnt = 4; with only 3 such beats, synced stays 1.
REQ-044 ACQ at lane 1 with acq_cnt = 2, then a comma at lane 3 -> align_lane = 3 and acq_cnt = 1; two more lane-3 commas -> SYNC.
REQ-045 BYTES=8: commas at bytes 1 and 5 -> align_lane = 1; each out_data word, bits [63:56] and [31:24], starts with 8'hBC.
REQ-046 err_word_cnt preloaded at 16'hFFFF plus an invalid beat -> stays 16'hFFFF; clear_cnt asserted in the same cycle as an increment -> 0.
REQ-047 in_valid gaps of 1..5 cycles inserted in SYNC traffic -> output byte order identical to the gap-free run, and reset_n pulsed low mid-stream -> all outputs 0 immediately.
